multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/mc_pkg.sv | 50 +++++
 rtl/mc_decode.sv | 70 +++++++
 rtl/multicycle_control.sv | 201 ++++++++++++++++++++
 tb/tb_multicycle_control.sv | 172 +++++++++++++++++
 4 files changed

// File: rtl/mc_pkg.sv
// Shared definitions for the multicycle controller: phase encodings,
// instruction path classes, opcode/funct constants and ALU function codes.
package mc_pkg;

    // Instruction phases; the numeric values are visible on the state port
    typedef enum logic [2:0] {
        S_IF  = 3'd0,
        S_ID  = 3'd1,
        S_EX  = 3'd2,
        S_MEM = 3'd3,
        S_WB  = 3'd4
    } state_t;

    // Which phase sequence an instruction follows after ID
    typedef enum logic [2:0] {
        PATH_ALU = 3'd0,   // ID-EX-WB   (R-type, addi, ori)
        PATH_LW  = 3'd1,   // ID-EX-MEM-WB
        PATH_SW  = 3'd2,   // ID-EX-MEM
        PATH_BEQ = 3'd3,   // ID-EX
        PATH_J   = 3'd4,   // ID
        PATH_ILL = 3'd5    // ID, then back to IF with illegal set
    } path_t;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD   = 6'h20;
    localparam logic [5:0] FN_ADDU  = 6'h21;
    localparam logic [5:0] FN_SUB   = 6'h22;
    localparam logic [5:0] FN_SUBU  = 6'h23;
    localparam logic [5:0] FN_AND   = 6'h24;
    localparam logic [5:0] FN_OR    = 6'h25;
    localparam logic [5:0] FN_SLT   = 6'h2A;

    localparam logic [2:0] ALU_ADD  = 3'd0;
    localparam logic [2:0] ALU_SUB  = 3'd1;
    localparam logic [2:0] ALU_AND  = 3'd2;
    localparam logic [2:0] ALU_OR   = 3'd3;
    localparam logic [2:0] ALU_SLT  = 3'd4;

    localparam logic [1:0] PC_SRC_SEQ = 2'd0;
    localparam logic [1:0] PC_SRC_BR  = 2'd1;
    localparam logic [1:0] PC_SRC_JMP = 2'd2;

endpackage

// File: rtl/mc_decode.sv
// Instruction decoder: latched op/func to datapath levels and path class.
// Unknown encodings decode to PATH_ILL with every control level at 0.
module mc_decode
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] func,
    output path_t           path,
    output logic [2:0]      alu_ctr,
    output logic            alu_src,
    output logic            ext_op,
    output logic            reg_dst,
    output logic            mem_to_reg,
    output logic            trap
);

    // Opcode/funct lookup; trap marks the signed ops that may raise overflow
    always_comb begin
        path       = PATH_ILL;
        alu_ctr    = ALU_ADD;
        alu_src    = 1'b0;
        ext_op     = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        trap       = 1'b0;
        case (op)
            OP_W'(OP_RTYPE): begin
                case (func)
                    OP_W'(FN_ADD):  begin path = PATH_ALU; alu_ctr = ALU_ADD; trap = 1'b1; end
                    OP_W'(FN_ADDU): begin path = PATH_ALU; alu_ctr = ALU_ADD; end
                    OP_W'(FN_SUB):  begin path = PATH_ALU; alu_ctr = ALU_SUB; trap = 1'b1; end
                    OP_W'(FN_SUBU): begin path = PATH_ALU; alu_ctr = ALU_SUB; end
                    OP_W'(FN_AND):  begin path = PATH_ALU; alu_ctr = ALU_AND; end
                    OP_W'(FN_OR):   begin path = PATH_ALU; alu_ctr = ALU_OR;  end
                    OP_W'(FN_SLT):  begin path = PATH_ALU; alu_ctr = ALU_SLT; end
                    default:        path = PATH_ILL;
                endcase
                if (path != PATH_ILL) begin
                    reg_dst = 1'b1;
                    ext_op  = 1'b1;
                end else begin
                    reg_dst = 1'b0;
                    ext_op  = 1'b0;
                end
            end
            OP_W'(OP_ADDI): begin
                path = PATH_ALU; alu_src = 1'b1; ext_op = 1'b1; trap = 1'b1;
            end
            OP_W'(OP_ORI): begin
                path = PATH_ALU; alu_src = 1'b1; ext_op = 1'b0; alu_ctr = ALU_OR;
            end
            OP_W'(OP_LW): begin
                path = PATH_LW; alu_src = 1'b1; ext_op = 1'b1; mem_to_reg = 1'b1;
            end
            OP_W'(OP_SW): begin
                path = PATH_SW; alu_src = 1'b1; ext_op = 1'b1;
            end
            OP_W'(OP_BEQ): begin
                path = PATH_BEQ; ext_op = 1'b1; alu_ctr = ALU_SUB;
            end
            OP_W'(OP_J): begin
                path = PATH_J; ext_op = 1'b1;
            end
            default: path = PATH_ILL;
        endcase
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle processor controller: Moore FSM stepping IF/ID/EX/MEM/WB.
// Outputs come from the state register and op/func captured with the IR
// load; only the branch decision in EX looks at the live Zero flag.
// Optional build macro: OVERFLOW_TRAP_EN (signed overflow blocks RegWr).
module multicycle_control
    import mc_pkg::*;
#(
    parameter int OP_W = 6
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [OP_W-1:0] op,
    input  logic [OP_W-1:0] func,
    input  logic            Zero,
    input  logic            Overflow,
    output logic [2:0]      state,
    output logic            ir_wr,
    output logic            pc_wr,
    output logic [1:0]      pc_src,
    output logic            WB_clk,
    output logic            RegWr,
    output logic            RegDst,
    output logic            ALUSrc,
    output logic            ExtOp,
    output logic            MemWr,
    output logic            MemtoReg,
    output logic [2:0]      ALUctr,
    output logic            illegal
);

    state_t          state_r;
    state_t          state_nxt_s;
    logic [OP_W-1:0] op_r;
    logic [OP_W-1:0] func_r;
    logic            illegal_r;
    logic            set_illegal_s;
    logic            trap_hit_s;
    logic            reg_block_s;

    path_t           dec_path_s;
    logic [2:0]      dec_alu_ctr_s;
    logic            dec_alu_src_s;
    logic            dec_ext_op_s;
    logic            dec_reg_dst_s;
    logic            dec_mem_to_reg_s;
    logic            dec_trap_s;

    mc_decode #(.OP_W(OP_W)) u_decode (
        .op         (op_r),
        .func       (func_r),
        .path       (dec_path_s),
        .alu_ctr    (dec_alu_ctr_s),
        .alu_src    (dec_alu_src_s),
        .ext_op     (dec_ext_op_s),
        .reg_dst    (dec_reg_dst_s),
        .mem_to_reg (dec_mem_to_reg_s),
        .trap       (dec_trap_s)
    );

    // Phase register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Capture op/func on the IR load edge so ID decodes from stable values
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_r   <= {OP_W{1'b0}};
            func_r <= {OP_W{1'b0}};
        end else if (state_r == S_IF) begin
            op_r   <= op;
            func_r <= func;
        end else begin
            op_r   <= op_r;
            func_r <= func_r;
        end
    end

`ifdef OVERFLOW_TRAP_EN
    logic ovf_r;

    // Remember an overflow seen in EX so WB can drop the register write
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_r <= 1'b0;
        end else if (state_r == S_EX) begin
            ovf_r <= Overflow & dec_trap_s;
        end else begin
            ovf_r <= ovf_r;
        end
    end

    assign trap_hit_s  = (state_r == S_EX) && Overflow && dec_trap_s;
    assign reg_block_s = ovf_r;
`else
    logic unused_ovf_s;
    assign unused_ovf_s = ^{Overflow, dec_trap_s};
    assign trap_hit_s   = 1'b0;
    assign reg_block_s  = 1'b0;
`endif

    assign set_illegal_s = ((state_r == S_ID) && (dec_path_s == PATH_ILL)) || trap_hit_s;

    // Sticky illegal flag, cleared only by reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (set_illegal_s) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    // Next phase from current phase and the decoded path class
    always_comb begin
        state_nxt_s = S_IF;
        case (state_r)
            S_IF:  state_nxt_s = S_ID;
            S_ID:  state_nxt_s = ((dec_path_s == PATH_J) || (dec_path_s == PATH_ILL)) ? S_IF : S_EX;
            S_EX: begin
                case (dec_path_s)
                    PATH_LW, PATH_SW: state_nxt_s = S_MEM;
                    PATH_ALU:         state_nxt_s = S_WB;
                    default:          state_nxt_s = S_IF;
                endcase
            end
            S_MEM: state_nxt_s = (dec_path_s == PATH_LW) ? S_WB : S_IF;
            S_WB:  state_nxt_s = S_IF;
            default: state_nxt_s = S_IF;
        endcase
    end

    // Phase strobes and datapath levels; everything is held at 0 in reset
    always_comb begin
        ir_wr    = 1'b0;
        pc_wr    = 1'b0;
        pc_src   = PC_SRC_SEQ;
        WB_clk   = 1'b0;
        RegWr    = 1'b0;
        MemWr    = 1'b0;
        RegDst   = 1'b0;
        ALUSrc   = 1'b0;
        ExtOp    = 1'b0;
        MemtoReg = 1'b0;
        ALUctr   = ALU_ADD;
        if (rst_n) begin
            RegDst   = dec_reg_dst_s;
            ALUSrc   = dec_alu_src_s;
            ExtOp    = dec_ext_op_s;
            MemtoReg = dec_mem_to_reg_s;
            ALUctr   = dec_alu_ctr_s;
            case (state_r)
                S_IF: ir_wr = 1'b1;
                S_ID: begin
                    if (dec_path_s == PATH_J) begin
                        pc_wr  = 1'b1;
                        pc_src = PC_SRC_JMP;
                    end else if (dec_path_s == PATH_ILL) begin
                        pc_wr  = 1'b1;
                        pc_src = PC_SRC_SEQ;
                    end else begin
                        pc_wr  = 1'b0;
                    end
                end
                S_EX: begin
                    if (dec_path_s == PATH_BEQ) begin
                        pc_wr  = 1'b1;
                        pc_src = Zero ? PC_SRC_BR : PC_SRC_SEQ;
                    end else begin
                        pc_wr  = 1'b0;
                    end
                end
                S_MEM: begin
                    if (dec_path_s == PATH_SW) begin
                        MemWr = 1'b1;
                        pc_wr = 1'b1;
                    end else begin
                        MemWr = 1'b0;
                    end
                end
                S_WB: begin
                    WB_clk = 1'b1;
                    RegWr  = ~reg_block_s;
                    pc_wr  = 1'b1;
                end
                default: ir_wr = 1'b0;
            endcase
        end else begin
            ir_wr = 1'b0;
        end
    end

    assign state   = state_r;
    assign illegal = illegal_r;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: a table of instructions checked
// cycle by cycle, plus hand sequences for overflow, illegal and reset.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [5:0] op = 6'h00;
    logic [5:0] func = 6'h00;
    logic       Zero = 1'b0;
    logic       Overflow = 1'b0;
    logic [2:0] state;
    logic       ir_wr, pc_wr, WB_clk, RegWr, RegDst, ALUSrc, ExtOp;
    logic       MemWr, MemtoReg, illegal;
    logic [1:0] pc_src;
    logic [2:0] ALUctr;

    int n_tests = 0;
    int n_fail  = 0;

    multicycle_control #(.OP_W(6)) dut (
        .clk(clk), .rst_n(rst_n), .op(op), .func(func), .Zero(Zero),
        .Overflow(Overflow), .state(state), .ir_wr(ir_wr), .pc_wr(pc_wr),
        .pc_src(pc_src), .WB_clk(WB_clk), .RegWr(RegWr), .RegDst(RegDst),
        .ALUSrc(ALUSrc), .ExtOp(ExtOp), .MemWr(MemWr), .MemtoReg(MemtoReg),
        .ALUctr(ALUctr), .illegal(illegal)
    );

    always #5 clk = ~clk;

    // {state, ir_wr, pc_wr, pc_src, WB_clk, RegWr, MemWr, illegal}
    logic [10:0] act_dyn;
    // {ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg}
    logic [6:0]  act_stat;
    assign act_dyn  = {state, ir_wr, pc_wr, pc_src, WB_clk, RegWr, MemWr, illegal};
    assign act_stat = {ALUctr, ALUSrc, ExtOp, RegDst, MemtoReg};

`ifdef OVERFLOW_TRAP_EN
    localparam logic EXP_OVF_RW  = 1'b0;
    localparam logic EXP_OVF_ILL = 1'b1;
`else
    localparam logic EXP_OVF_RW  = 1'b1;
    localparam logic EXP_OVF_ILL = 1'b0;
`endif

    // phase k of the instruction lives at bits [3k+2:3k]
    localparam logic [14:0] P_ALU = {3'd0, 3'd4, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_LW  = {3'd4, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_SW  = {3'd0, 3'd3, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_BEQ = {3'd0, 3'd0, 3'd2, 3'd1, 3'd0};
    localparam logic [14:0] P_J   = {3'd0, 3'd0, 3'd0, 3'd1, 3'd0};

    typedef struct {
        string       name;
        logic [5:0]  op;
        logic [5:0]  func;
        logic        zero;
        logic        ovf;
        int          n;
        logic [14:0] states;
        logic        regwr;
        logic        memwr;
        logic [1:0]  pcsrc;
        logic [6:0]  stat;
    } vec_t;

    vec_t vecs[15];

    function automatic vec_t mk(string nm, logic [5:0] o, logic [5:0] f,
                                logic z, logic ov, int n, logic [14:0] st,
                                logic rw, logic mw, logic [1:0] ps, logic [6:0] sb);
        vec_t v;
        v.name = nm; v.op = o; v.func = f; v.zero = z; v.ovf = ov; v.n = n;
        v.states = st; v.regwr = rw; v.memwr = mw; v.pcsrc = ps; v.stat = sb;
        return v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Entry: just after a negedge with the DUT in IF. Exit: same.
    task automatic run_vec(input vec_t v);
        logic [2:0]  s;
        logic [10:0] exp_dyn;
        op = v.op; func = v.func; Zero = v.zero; Overflow = v.ovf;
        #1;
        for (int k = 0; k < v.n; k++) begin
            if (k > 0) @(negedge clk);
            s = v.states[3*k +: 3];
            exp_dyn = {s, (s == 3'd0), (k == v.n - 1),
                       (k == v.n - 1) ? v.pcsrc : 2'd0,
                       (s == 3'd4), (s == 3'd4) & v.regwr,
                       (s == 3'd3) & v.memwr, 1'b0};
            check($sformatf("%s c%0d outputs", v.name, k), 32'(act_dyn), 32'(exp_dyn));
            if (k == 1) check($sformatf("%s levels", v.name), 32'(act_stat), 32'(v.stat));
        end
        @(negedge clk);
    endtask

    initial begin
        vecs[0]  = mk("add",     6'h00, 6'h20, 1'b0, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b000_0110);
        vecs[1]  = mk("addu_ov", 6'h00, 6'h21, 1'b0, 1'b1, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b000_0110);
        vecs[2]  = mk("sub",     6'h00, 6'h22, 1'b1, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b001_0110);
        vecs[3]  = mk("subu",    6'h00, 6'h23, 1'b0, 1'b1, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b001_0110);
        vecs[4]  = mk("and",     6'h00, 6'h24, 1'b0, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b010_0110);
        vecs[5]  = mk("or",      6'h00, 6'h25, 1'b0, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b011_0110);
        vecs[6]  = mk("slt",     6'h00, 6'h2A, 1'b0, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b100_0110);
        vecs[7]  = mk("addi",    6'h08, 6'h00, 1'b0, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b000_1100);
        vecs[8]  = mk("ori",     6'h0D, 6'h00, 1'b0, 1'b1, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b011_1000);
        vecs[9]  = mk("lw",      6'h23, 6'h00, 1'b0, 1'b0, 5, P_LW,  1'b1, 1'b0, 2'd0, 7'b000_1101);
        vecs[10] = mk("sw",      6'h2B, 6'h00, 1'b0, 1'b0, 4, P_SW,  1'b0, 1'b1, 2'd0, 7'b000_1100);
        vecs[11] = mk("beq_z1",  6'h04, 6'h00, 1'b1, 1'b0, 3, P_BEQ, 1'b0, 1'b0, 2'd1, 7'b001_0100);
        vecs[12] = mk("beq_z0",  6'h04, 6'h00, 1'b0, 1'b0, 3, P_BEQ, 1'b0, 1'b0, 2'd0, 7'b001_0100);
        vecs[13] = mk("j",       6'h02, 6'h00, 1'b0, 1'b0, 2, P_J,   1'b0, 1'b0, 2'd2, 7'b000_0100);
        vecs[14] = mk("add2",    6'h00, 6'h20, 1'b1, 1'b0, 4, P_ALU, 1'b1, 1'b0, 2'd0, 7'b000_0110);

        // Reset: everything low, including ir_wr even though the phase is IF
        @(negedge clk);
        check("reset outputs", 32'(act_dyn), 32'd0);
        check("reset levels", 32'(act_stat), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Table: first vector's cycle 0 also checks fetch right after reset
        for (int i = 0; i < 15; i++) run_vec(vecs[i]);

        // add with overflow: trap depends on the build
        op = 6'h00; func = 6'h20; Zero = 1'b0; Overflow = 1'b1;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("ovf add state", 32'(state), 32'd4);
        check("ovf add WB_clk", 32'(WB_clk), 32'd1);
        check("ovf add RegWr", 32'(RegWr), 32'(EXP_OVF_RW));
        check("ovf add illegal", 32'(illegal), 32'(EXP_OVF_ILL));
        @(negedge clk);
        Overflow = 1'b0;
        rst_n = 1'b0;
        #1;
        check("reset clears illegal", 32'(illegal), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Unknown opcode: pc_wr in ID, back to IF with illegal set, no writes
        op = 6'h3F; func = 6'h00;
        #1;
        check("ill c0", 32'(act_dyn), 32'(11'b000_1_0_00_0_0_0_0));
        @(negedge clk);
        check("ill ID", 32'(act_dyn), 32'(11'b001_0_1_00_0_0_0_0));
        @(negedge clk);
        check("ill back to IF", 32'(act_dyn), 32'(11'b000_1_0_00_0_0_0_1));

        // lw interrupted by reset in MEM
        op = 6'h23; func = 6'h00;
        @(negedge clk); @(negedge clk); @(negedge clk);
        check("lw reached MEM", 32'(act_dyn), 32'(11'b011_0_0_00_0_0_0_1));
        rst_n = 1'b0;
        #1;
        check("mid-lw reset outputs", 32'(act_dyn), 32'd0);
        check("mid-lw reset levels", 32'(act_stat), 32'd0);
        @(negedge clk);
        check("held reset outputs", 32'(act_dyn), 32'd0);
        rst_n = 1'b1;
        run_vec(vecs[0]);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
